// File: rtl/vga_timing_sink.sv
// VGA raster timing generator and output stage: free-running h/v counters, registered
// colour/sync/blank to the DAC, and a once-per-frame display-mode latch with frame counter.
module vga_timing_sink #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_R,
    input  logic [7:0]  in_G,
    input  logic [7:0]  in_B,
    input  logic [1:0]  key_ctr,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic [1:0]  mode_frame,
    output logic [15:0] frame_cnt
);

    localparam int unsigned CW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic [1:0]    mode_q, mode_d;
    logic [15:0]   frame_q, frame_d;
    logic          h_wrap, frame_latch, visible;

    assign visible = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign pix_req = visible;
    assign pix_x   = h_cnt_q;
    assign pix_y   = v_cnt_q;

    // Raster counters; vertical advances only on the horizontal wrap.
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
        end
    end

    // Output stage: everything here is one clock behind the counter position.
    always_comb begin
        r_d       = visible ? in_R : 8'h00;
        g_d       = visible ? in_G : 8'h00;
        b_d       = visible ? in_B : 8'h00;
        hs_d      = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vs_d      = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        blank_n_d = visible;
    end

    // Mode is sampled only at the start of vertical blank so it never changes mid-frame.
    always_comb begin
        frame_latch = (h_cnt_q == '0) && (v_cnt_q == V_VIS);
        mode_d      = mode_q;
        frame_d     = frame_q;
        if (frame_latch) begin
            mode_d  = key_ctr;
            frame_d = frame_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
            mode_q    <= 2'b11;
            frame_q   <= 16'h0000;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            mode_q    <= mode_d;
            frame_q   <= frame_d;
        end
    end

    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;
    assign mode_frame  = mode_q;
    assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_vga_timing_sink.sv
// Bench for vga_timing_sink with a reduced raster (30 x 19) so whole frames fit in a short run.
module tb_vga_timing_sink;

    localparam int H_ACTIVE = 16, H_FP = 4, H_SYNC = 6, H_BP = 4;
    localparam int V_ACTIVE = 12, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int HS_LO    = H_ACTIVE + H_FP;
    localparam int HS_HI    = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_LO    = V_ACTIVE + V_FP;
    localparam int VS_HI    = V_ACTIVE + V_FP + V_SYNC - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_R, in_G, in_B;
    logic [1:0]  key_ctr;
    logic        pix_req;
    logic [9:0]  pix_x, pix_y;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [1:0]  mode_frame;
    logic [15:0] frame_cnt;

    vga_timing_sink #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .clk(clk), .reset(reset),
        .in_R(in_R), .in_G(in_G), .in_B(in_B), .key_ctr(key_ctr),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .mode_frame(mode_frame), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  r, g, b;
        logic        hs, vs, blank_n;
        logic [1:0]  mode;
        logic [15:0] frame;
    } exp_t;

    typedef struct {
        int         h, v;
        logic       rst;
        logic [7:0] r;
        logic       exp_preq;
        logic [7:0] exp_r;
        logic       exp_blank_n, exp_hs, exp_vs;
    } vec_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          mh, mv;
    logic [1:0]  m_mode;
    logic [15:0] m_frame;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: check combinational outputs, queue the expected registered outputs,
    // advance the reference position, then pop and compare after the edge.
    task automatic step();
        exp_t e, got;
        logic preq, latch;
        if (errors > 40) begin
            @(negedge clk);
            return;
        end
        preq  = (mh < H_ACTIVE) && (mv < V_ACTIVE);
        latch = (mh == 0) && (mv == V_ACTIVE);
        chk("pix_req", 32'(pix_req), 32'(preq));
        chk("pix_x", 32'(pix_x), 32'(mh));
        chk("pix_y", 32'(pix_y), 32'(mv));
        if (reset) begin
            e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
            e.hs = 1'b1; e.vs = 1'b1; e.blank_n = 1'b0;
            e.mode = 2'b11; e.frame = 16'h0000;
            mh = 0; mv = 0;
        end else begin
            e.r = preq ? in_R : 8'h00;
            e.g = preq ? in_G : 8'h00;
            e.b = preq ? in_B : 8'h00;
            e.hs = !((mh >= HS_LO) && (mh <= HS_HI));
            e.vs = !((mv >= VS_LO) && (mv <= VS_HI));
            e.blank_n = preq;
            e.mode  = latch ? key_ctr : m_mode;
            e.frame = latch ? m_frame + 16'd1 : m_frame;
            if (mh == H_TOTAL - 1) begin
                mh = 0;
                mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        m_mode  = e.mode;
        m_frame = e.frame;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        chk("VGA_R", 32'(VGA_R), 32'(got.r));
        chk("VGA_G", 32'(VGA_G), 32'(got.g));
        chk("VGA_B", 32'(VGA_B), 32'(got.b));
        chk("VGA_HS", 32'(VGA_HS), 32'(got.hs));
        chk("VGA_VS", 32'(VGA_VS), 32'(got.vs));
        chk("VGA_BLANK_N", 32'(VGA_BLANK_N), 32'(got.blank_n));
        chk("VGA_SYNC_N", 32'(VGA_SYNC_N), 32'(1'b0));
        chk("mode_frame", 32'(mode_frame), 32'(got.mode));
        chk("frame_cnt", 32'(frame_cnt), 32'(got.frame));
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (mh == h && mv == v) return;
            step();
        end
        chk($sformatf("reach_%0d_%0d", h, v), 32'(0), 32'(1));
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    vec_t vecs[14];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_lows, hs_first, vs_lows, vs_first, fr_idx;
        logic [15:0] f0;

        //           h   v  rst  r      preq  exp_r  blank hs  vs
        vecs[0]  = '{0,  0, 0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{15, 3, 0, 8'h11, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{16, 3, 0, 8'h22, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{20, 3, 0, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{25, 3, 0, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{26, 3, 0, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{5, 12, 0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{3, 14, 0, 8'h66, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{29, 15, 0, 8'h77, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{0, 16, 0, 8'h88, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{22, 18, 0, 8'h99, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{0,  0, 0, 8'h12, 1'b1, 8'h12, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{8,  5, 1, 8'hAB, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{0,  0, 0, 8'h34, 1'b1, 8'h34, 1'b1, 1'b1, 1'b1};

        reset = 1'b1; in_R = 8'hA5; in_G = 8'h5A; in_B = 8'h3C; key_ctr = 2'b11;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mh = 0; mv = 0; m_mode = 2'b11; m_frame = 16'h0000;

        // Reset state and first position after release
        chk("rst_VGA_R", 32'(VGA_R), 32'(8'h00));
        chk("rst_VGA_HS", 32'(VGA_HS), 32'(1'b1));
        chk("rst_VGA_VS", 32'(VGA_VS), 32'(1'b1));
        chk("rst_BLANK_N", 32'(VGA_BLANK_N), 32'(1'b0));
        chk("rst_mode", 32'(mode_frame), 32'(2'b11));
        chk("rst_frame", 32'(frame_cnt), 32'(16'h0));
        chk("rst_pix_req", 32'(pix_req), 32'(1'b1));
        chk("rst_pix_x", 32'(pix_x), 32'(0));

        for (int i = 0; i < 14; i++) begin
            run_to(vecs[i].h, vecs[i].v);
            reset = vecs[i].rst;
            in_R  = vecs[i].r;
            chk($sformatf("vec%0d_pix_req", i), 32'(pix_req), 32'(vecs[i].exp_preq));
            step();
            reset = 1'b0;
            in_R  = 8'hA5;
            chk($sformatf("vec%0d_VGA_R", i), 32'(VGA_R), 32'(vecs[i].exp_r));
            chk($sformatf("vec%0d_BLANK_N", i), 32'(VGA_BLANK_N), 32'(vecs[i].exp_blank_n));
            chk($sformatf("vec%0d_HS", i), 32'(VGA_HS), 32'(vecs[i].exp_hs));
            chk($sformatf("vec%0d_VS", i), 32'(VGA_VS), 32'(vecs[i].exp_vs));
        end

        // Reset mid-frame while both syncs are low
        run_to(22, 15);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_x", 32'(pix_x), 32'(0));
        chk("mid_rst_y", 32'(pix_y), 32'(0));
        chk("mid_rst_hs", 32'(VGA_HS), 32'(1'b1));
        chk("mid_rst_vs", 32'(VGA_VS), 32'(1'b1));
        chk("mid_rst_frame", 32'(frame_cnt), 32'(16'h0));
        chk("mid_rst_mode", 32'(mode_frame), 32'(2'b11));

        // Mode change mid-frame is held off until the vertical-blank latch
        run_to(10, 5);
        key_ctr = 2'b01;
        run_to(0, 12);
        chk("mode_hold", 32'(mode_frame), 32'(2'b11));
        step();
        chk("mode_latched", 32'(mode_frame), 32'(2'b01));
        chk("frame_after_latch", 32'(frame_cnt), 32'(16'd1));
        key_ctr = 2'b10;
        run_to(0, 0);
        chk("mode_ignored", 32'(mode_frame), 32'(2'b01));
        run_to(0, 12);
        step();
        chk("mode_relatched", 32'(mode_frame), 32'(2'b10));

        // Horizontal sync width, position and line period
        run_to(0, 1);
        hs_lows = 0; hs_first = 0;
        for (int i = 1; i <= H_TOTAL; i++) begin
            step();
            if (VGA_HS === 1'b0) begin
                hs_lows++;
                if (hs_first == 0) hs_first = i;
            end
        end
        chk("hs_low_clocks", 32'(hs_lows), 32'(H_SYNC));
        chk("hs_first_clock", 32'(hs_first), 32'(HS_LO + 1));
        chk("line_period_x", 32'(pix_x), 32'(0));
        chk("line_period_y", 32'(pix_y), 32'(2));

        // Vertical sync width, frame period and frame counter timing
        run_to(0, 0);
        f0 = frame_cnt;
        vs_lows = 0; vs_first = 0; fr_idx = 0;
        for (int i = 1; i <= FRAME; i++) begin
            step();
            if (VGA_VS === 1'b0) begin
                vs_lows++;
                if (vs_first == 0) vs_first = i;
            end
            if (fr_idx == 0 && frame_cnt !== f0) fr_idx = i;
        end
        chk("vs_low_clocks", 32'(vs_lows), 32'(V_SYNC * H_TOTAL));
        chk("vs_first_clock", 32'(vs_first), 32'(VS_LO * H_TOTAL + 1));
        chk("frame_inc_clock", 32'(fr_idx), 32'(V_ACTIVE * H_TOTAL + 1));
        chk("frame_inc_value", 32'(frame_cnt), 32'(f0 + 16'd1));
        chk("frame_period_x", 32'(pix_x), 32'(0));
        chk("frame_period_y", 32'(pix_y), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
